mem_port_arbiter: RTL and testbench

- Shares one single-port 16-bit memory between the fetch stage (read-only) and the mem stage (read/write) of the 5-stage pipeline.
- Sequences each access with a req/ready handshake toward memory and a req/done handshake toward each stage.
- Data accesses have priority; a bounded-streak rule guarantees fetch progress; a watchdog aborts hung accesses.

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port 16-bit memory between the fetch stage (read-only)
//   and the mem stage (read/write). Data accesses win arbitration, a streak
//   limit keeps fetch moving, and a watchdog aborts accesses whose memory
//   never answers.
//
// Ports
//   clock, rst            rising-edge clock, async active-low reset
//   if_req/if_addr        fetch request (level, held until if_done)
//   if_rdata/if_done      fetch read data, valid during the one-cycle done pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request (level, held until dm_done)
//   dm_rdata/dm_done      data read data, valid during the one-cycle done pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory strobe and latched command
//   mem_rdata/mem_ready   memory return data and completion
//   busy                  access in flight
//   bus_err               accompanies a done pulse for a watchdog-aborted access
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no access in flight; arbitrate unmasked requests
// IF_BUSY | fetch access presented to memory, waiting for mem_ready
// DM_BUSY | data access presented to memory, waiting for mem_ready

module mem_port_arbiter #(
  parameter int unsigned DM_STREAK_MAX = 3,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(DM_STREAK_MAX);
  localparam bit         TMO_EN     = (TIMEOUT != 0);
  // Abort is decided in the last waiting cycle, so the compare value is one
  // below TIMEOUT; this keeps mem_req high for exactly TIMEOUT cycles.
  localparam logic [7:0] TMO_LAST   = TMO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] dm_rdata_q, dm_rdata_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic        bus_err_q, bus_err_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tmo_q, tmo_d;

  logic        if_req_m, dm_req_m;
  logic        if_grant, dm_grant;

  // A requester that is seeing its done pulse is not re-granted that cycle,
  // giving it time to drop req.
  assign if_req_m = if_req & ~if_done_q;
  assign dm_req_m = dm_req & ~dm_done_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    bus_err_d  = 1'b0;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    if_grant   = 1'b0;
    dm_grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_req_m && !(if_req_m && (streak_q == STREAK_MAX))) begin
          dm_grant = 1'b1;
          state_d  = DM_BUSY;
          addr_d   = dm_addr;
          we_d     = dm_we;
          wdata_d  = dm_wdata;
          tmo_d    = 8'd0;
        end else if (if_req_m) begin
          if_grant = 1'b1;
          state_d  = IF_BUSY;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = 16'h0000;
          tmo_d    = 8'd0;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ready) begin
          state_d = IDLE;
          if (state_q == IF_BUSY) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = we_q ? 16'h0000 : mem_rdata;
          end
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          state_d   = IDLE;
          bus_err_d = 1'b1;
          if (state_q == IF_BUSY) begin
            if_done_d  = 1'b1;
            if_rdata_d = 16'h0000;
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = 16'h0000;
          end
        end else if (TMO_EN) begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!if_req || if_grant) begin
      streak_d = 4'd0;
    end else if (dm_grant && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      we_q       <= 1'b0;
      wdata_q    <= 16'h0000;
      if_rdata_q <= 16'h0000;
      dm_rdata_q <= 16'h0000;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      streak_q   <= 4'd0;
      tmo_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      bus_err_q  <= bus_err_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_req   = busy;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_done   = dm_done_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against a
// transaction-level model of the arbiter.

module tb_mem_port_arbiter;

  localparam int P_STREAK = 3;
  localparam int P_TMO    = 4;

  logic        clock, rst;
  logic        if_req;
  logic [15:0] if_addr, if_rdata;
  logic        if_done;
  logic        dm_req, dm_we;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_done;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, busy, bus_err;

  int checks = 0;
  int errors = 0;

  // model state: owner 0 = none, 1 = fetch, 2 = data
  int          e_owner, e_wait, e_streak;
  logic        e_we;
  logic [15:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;
  logic        e_if_done, e_dm_done, e_err;
  // model scratch
  logic        m_if_pend, m_dm_pend, m_fin, m_abort, m_nif, m_ndm, m_nerr;
  int          m_grant;

  int exp_code [8] = '{2, 0, 1, 0, 2, 0, 1, 0};

  mem_port_arbiter #(.DM_STREAK_MAX(P_STREAK), .TIMEOUT(P_TMO)) dut (
    .clock(clock), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .bus_err(bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the port, how long it has waited,
  // and what each stage must see when its access finishes.
  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      e_owner = 0; e_wait = 0; e_streak = 0;
      e_we = 1'b0; e_addr = 16'h0; e_wdata = 16'h0;
      e_if_rdata = 16'h0; e_dm_rdata = 16'h0;
      e_if_done = 1'b0; e_dm_done = 1'b0; e_err = 1'b0;
    end else begin
      m_if_pend = if_req && !e_if_done;
      m_dm_pend = dm_req && !e_dm_done;
      m_grant = 0;
      m_nif = 1'b0; m_ndm = 1'b0; m_nerr = 1'b0;
      if (e_owner == 0) begin
        if (m_dm_pend && !(m_if_pend && e_streak >= P_STREAK)) m_grant = 2;
        else if (m_if_pend) m_grant = 1;
      end else begin
        m_fin = 1'b0; m_abort = 1'b0;
        if (mem_ready) m_fin = 1'b1;
        else begin
          e_wait++;
          if (P_TMO > 0 && e_wait >= P_TMO) begin m_fin = 1'b1; m_abort = 1'b1; end
        end
        if (m_fin) begin
          if (e_owner == 1) begin
            m_nif = 1'b1;
            e_if_rdata = m_abort ? 16'h0 : mem_rdata;
          end else begin
            m_ndm = 1'b1;
            e_dm_rdata = (m_abort || e_we) ? 16'h0 : mem_rdata;
          end
          m_nerr = m_abort;
          e_owner = 0;
        end
      end
      if (!if_req || m_grant == 1) e_streak = 0;
      else if (m_grant == 2 && e_streak < P_STREAK) e_streak++;
      if (m_grant == 2) begin
        e_owner = 2; e_wait = 0; e_addr = dm_addr; e_we = dm_we; e_wdata = dm_wdata;
      end else if (m_grant == 1) begin
        e_owner = 1; e_wait = 0; e_addr = if_addr; e_we = 1'b0; e_wdata = 16'h0;
      end
      e_if_done = m_nif; e_dm_done = m_ndm; e_err = m_nerr;
    end
  end

  always @(negedge clock) begin
    if (rst === 1'b1) begin
      chk1("cyc_busy", busy, e_owner != 0);
      chk1("cyc_mem_req", mem_req, e_owner != 0);
      chk1("cyc_if_done", if_done, e_if_done);
      chk1("cyc_dm_done", dm_done, e_dm_done);
      chk1("cyc_bus_err", bus_err, e_err);
      if (e_owner != 0) begin
        chk16("cyc_mem_addr", mem_addr, e_addr);
        chk1("cyc_mem_we", mem_we, e_we);
        chk16("cyc_mem_wdata", mem_wdata, e_wdata);
      end
      if (e_if_done) chk16("cyc_if_rdata", if_rdata, e_if_rdata);
      if (e_dm_done) chk16("cyc_dm_rdata", dm_rdata, e_dm_rdata);
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg;
    @(negedge clock);
  endtask

  task automatic quiet;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk1({name, "_mem_req"}, mem_req, 1'b0);
    chk1({name, "_busy"}, busy, 1'b0);
    chk1({name, "_if_done"}, if_done, 1'b0);
    chk1({name, "_dm_done"}, dm_done, 1'b0);
    chk1({name, "_bus_err"}, bus_err, 1'b0);
    chk16({name, "_mem_addr"}, mem_addr, 16'h0);
    chk16({name, "_if_rdata"}, if_rdata, 16'h0);
    chk16({name, "_dm_rdata"}, dm_rdata, 16'h0);
  endtask

  int ready_pct;
  int code;

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;
    mem_rdata = 16'h0; mem_ready = 1'b0;

    // reset held for three cycles, then idle with no requests
    for (int i = 0; i < 3; i++) begin
      at_neg;
      chk_all_zero("reset");
    end
    tick;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      at_neg;
      chk_all_zero("idle");
    end

    // single fetch, one wait cycle, done three cycles after req
    tick;
    if_req = 1'b1; if_addr = 16'h0010;
    tick;
    at_neg;
    chk1("fetch_mem_req", mem_req, 1'b1);
    chk16("fetch_mem_addr", mem_addr, 16'h0010);
    chk1("fetch_mem_we", mem_we, 1'b0);
    tick;
    mem_ready = 1'b1; mem_rdata = 16'hABCD;
    at_neg;
    chk1("fetch_no_early_done", if_done, 1'b0);
    tick;
    mem_ready = 1'b0;
    at_neg;
    chk1("fetch_done", if_done, 1'b1);
    chk16("fetch_rdata", if_rdata, 16'hABCD);
    chk16("fetch_model_rdata", e_if_rdata, 16'hABCD);
    chk1("fetch_busy_after", busy, 1'b0);
    if_req = 1'b0;
    tick;
    at_neg;
    chk1("fetch_done_one_cycle", if_done, 1'b0);

    // collision on a zero-wait memory: data write first, then fetch
    tick;
    if_req = 1'b1; if_addr = 16'h0300;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    tick;
    dm_addr = 16'hFFFF; dm_wdata = 16'hEEEE; dm_we = 1'b0;
    at_neg;
    chk1("coll_dm_we", mem_we, 1'b1);
    chk16("coll_dm_addr", mem_addr, 16'h0200);
    chk16("coll_dm_wdata", mem_wdata, 16'h1234);
    tick;
    dm_req = 1'b0;
    at_neg;
    chk1("coll_dm_done", dm_done, 1'b1);
    chk16("coll_dm_rdata_write", dm_rdata, 16'h0000);
    tick;
    at_neg;
    chk1("coll_if_granted", mem_req, 1'b1);
    chk16("coll_if_addr", mem_addr, 16'h0300);
    chk16("coll_if_wdata", mem_wdata, 16'h0000);
    tick;
    if_req = 1'b0;
    at_neg;
    chk1("coll_if_done", if_done, 1'b1);
    chk16("coll_if_rdata", if_rdata, 16'h5A5A);
    quiet;
    tick; tick;

    // both held on a zero-wait memory: done-cycle masking hands the port to
    // fetch after every data access, well inside the DM_STREAK_MAX bound
    if_req = 1'b1; if_addr = 16'h1000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h2000;
    mem_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick;
      at_neg;
      code = mem_req ? int'(mem_addr[15:12]) : 0;
      checks++;
      if (code != exp_code[c]) begin
        errors++;
        $display("FAIL streak_order cycle %0d: got owner code %0d expected %0d", c + 1, code, exp_code[c]);
      end
    end
    quiet;
    tick; tick;

    // watchdog on a data read with no mem_ready
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0444;
    for (int k = 0; k < 4; k++) begin
      tick;
      at_neg;
      chk1("tmo_mem_req_held", mem_req, 1'b1);
    end
    tick;
    at_neg;
    chk1("tmo_dm_done", dm_done, 1'b1);
    chk1("tmo_bus_err", bus_err, 1'b1);
    chk1("tmo_model_err", e_err, 1'b1);
    chk16("tmo_dm_rdata", dm_rdata, 16'h0000);
    chk1("tmo_busy", busy, 1'b0);
    chk1("tmo_mem_req", mem_req, 1'b0);
    dm_req = 1'b0;
    tick; tick;

    // async reset during the second DM_BUSY cycle
    dm_req = 1'b1; dm_addr = 16'h0555;
    tick;
    tick;
    #2;
    rst = 1'b0;
    #1;
    chk1("arst_mem_req", mem_req, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    dm_req = 1'b0;
    tick; tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      at_neg;
      chk1("arst_no_stale_dm_done", dm_done, 1'b0);
      chk1("arst_no_stale_if_done", if_done, 1'b0);
      tick;
    end
    if_req = 1'b1; if_addr = 16'h0666; mem_ready = 1'b1; mem_rdata = 16'h7777;
    tick;
    at_neg;
    chk16("arst_if_addr", mem_addr, 16'h0666);
    tick;
    at_neg;
    chk1("arst_if_done", if_done, 1'b1);
    chk16("arst_if_rdata", if_rdata, 16'h7777);
    quiet;
    tick; tick;

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      ready_pct = ((c % 1000) < 800) ? 70 : 12;
      tick;
      if (c == 2601) rst = 1'b1;
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      mem_rdata = 16'($urandom);
      if (if_req && if_done) begin
        if ($urandom_range(0, 1) == 0) if_req = 1'b0;
        else if_addr = 16'($urandom);
      end else if (!if_req) begin
        if ($urandom_range(0, 2) == 0) begin if_req = 1'b1; if_addr = 16'($urandom); end
      end else if (e_owner == 1 && $urandom_range(0, 3) == 0) begin
        if_addr = 16'($urandom);
      end
      if (dm_req && dm_done) begin
        if ($urandom_range(0, 1) == 0) dm_req = 1'b0;
        else begin dm_addr = 16'($urandom); dm_wdata = 16'($urandom); dm_we = 1'($urandom); end
      end else if (!dm_req) begin
        if ($urandom_range(0, 1) == 0) begin
          dm_req = 1'b1; dm_addr = 16'($urandom); dm_wdata = 16'($urandom); dm_we = 1'($urandom);
        end
      end else if (e_owner == 2 && $urandom_range(0, 3) == 0) begin
        dm_addr = 16'($urandom); dm_wdata = 16'($urandom); dm_we = 1'($urandom);
      end
      if (c == 2600) begin
        #2;
        rst = 1'b0;
        #1;
        chk1("rand_arst_mem_req", mem_req, 1'b0);
      end
    end
    quiet;
    tick; tick; tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
